// File: rtl/rpi_if_pkg.sv
// ============================================================================
// rpi_if_pkg : shared encodings and defaults for the RPi <-> FPGA serial link
// Rev 1.0
// ============================================================================
`default_nettype none

package rpi_if_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam int SYNC_STAGES     = 2;
    localparam int DEFAULT_WORD_W  = 16;
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

`default_nettype wire

// File: rtl/rpi_sync_edge.sv
// ============================================================================
// rpi_sync_edge : multi-flop pin synchronizer plus one edge-detect flop
// Rev 1.0
// ============================================================================
`default_nettype none

module rpi_sync_edge
    import rpi_if_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // r_sync[0] is the metastability catcher; the top bit is the edge-detect flop
    logic [SYNC_STAGES:0] r_sync;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-1:0], async_in};
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
    assign fall  = ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES];

endmodule

`default_nettype wire

// File: rtl/rpi_serial_rx.sv
// ============================================================================
// rpi_serial_rx : deserializes the RPi sclk/sdata/cs_n stream into words
// Rev 1.0
// ============================================================================
`default_nettype none

module rpi_serial_rx
    import rpi_if_pkg::*;
#(
    parameter int WORD_W  = DEFAULT_WORD_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              rpi_sclk,
    input  logic              rpi_sdata,
    input  logic              rpi_cs_n,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_error,
    input  logic              err_clear
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    logic w_sclk_rise, w_cs_level, w_cs_rise, w_data_level;
    logic w_unused_sclk_level, w_unused_sclk_fall, w_unused_cs_fall;
    logic w_unused_data_rise, w_unused_data_fall;

    rpi_sync_edge u_sync_sclk (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_in(rpi_sclk),
        .level   (w_unused_sclk_level),
        .rise    (w_sclk_rise),
        .fall    (w_unused_sclk_fall)
    );

    rpi_sync_edge u_sync_cs (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_in(rpi_cs_n),
        .level   (w_cs_level),
        .rise    (w_cs_rise),
        .fall    (w_unused_cs_fall)
    );

    rpi_sync_edge u_sync_data (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_in(rpi_sdata),
        .level   (w_data_level),
        .rise    (w_unused_data_rise),
        .fall    (w_unused_data_fall)
    );

    rx_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic [WORD_W-1:0] r_shift, w_shift_nxt;
    logic              r_done, w_done_nxt;
    logic              w_abort;
    logic [WORD_W-1:0] r_rx_data;
    logic              r_rx_valid, r_busy, r_overrun, r_frame_error;
    logic              w_load;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_tmo_nxt = '0;
                if (!w_cs_level) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_abort     = (r_cnt != '0);
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_nxt = {r_shift[WORD_W-2:0], w_data_level};
                    w_tmo_nxt   = '0;
                    if (r_cnt == CNT_W'(WORD_W - 1)) begin
                        w_cnt_nxt  = '0;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (r_cnt != '0) begin
                    // stalled clock mid-word: abandon the partial word, stay in frame
                    if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        w_abort   = 1'b1;
                        w_cnt_nxt = '0;
                        w_tmo_nxt = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end else begin
                    w_tmo_nxt = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // a completed word is offered one cycle after the shift register fills
    assign w_load = r_done && (!r_rx_valid || rx_ready);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_shift       <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_cnt_nxt != '0);
            if (w_load) begin
                r_rx_data <= r_shift;
            end
            if (w_load) begin
                r_rx_valid <= 1'b1;
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (r_done && !w_load) begin
                r_overrun <= 1'b1;
            end else if (err_clear) begin
                r_overrun <= 1'b0;
            end
            if (w_abort) begin
                r_frame_error <= 1'b1;
            end else if (err_clear) begin
                r_frame_error <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign frame_error = r_frame_error;

endmodule

`default_nettype wire

// File: tb/tb_rpi_serial_rx.sv
// ============================================================================
// tb_rpi_serial_rx : directed self-checking bench for rpi_serial_rx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rpi_serial_rx;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        rpi_sclk, rpi_sdata, rpi_cs_n;
    logic [15:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        busy, overrun, frame_error, err_clear;

    int checks = 0;
    int errors = 0;

    rpi_serial_rx #(.WORD_W(16), .TIMEOUT(1024)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .rpi_sclk   (rpi_sclk),
        .rpi_sdata  (rpi_sdata),
        .rpi_cs_n   (rpi_cs_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_error(frame_error),
        .err_clear  (err_clear)
    );

    always #10 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // sclk low phase with data set up; returns at the instant sclk rises
    task automatic bit_setup(input logic b);
        rpi_sdata = b;
        rpi_sclk  = 1'b0;
        wait_neg(5);
        rpi_sclk  = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        bit_setup(b);
        wait_neg(5);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(w[15-i]);
        end
    endtask

    task automatic frame_start();
        rpi_cs_n = 1'b0;
        wait_neg(4);
    endtask

    task automatic frame_end();
        rpi_cs_n = 1'b1;
        wait_neg(6);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        wait_neg(1);
        err_clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        rpi_sclk  = 1'b0;
        rpi_sdata = 1'b0;
        rpi_cs_n  = 1'b1;
        rx_ready  = 1'b1;
        err_clear = 1'b0;
        wait_neg(3);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        reset = 1'b0;
        wait_neg(2);

        // single word, consumer always ready: one-cycle valid, 4 cycles after last rise
        frame_start();
        send_bits(16'hA5C3, 15);
        bit_setup(1'b1);
        wait_neg(3);
        check("t1_valid_early", 32'(rx_valid), 32'h0);
        wait_neg(1);
        check("t1_valid", 32'(rx_valid), 32'h1);
        check("t1_data", 32'(rx_data), 32'hA5C3);
        wait_neg(1);
        check("t1_valid_pulse", 32'(rx_valid), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_overrun", 32'(overrun), 32'h0);
        check("t1_frame_error", 32'(frame_error), 32'h0);
        wait_neg(4);
        frame_end();

        // two words, consumer stalled: second word dropped
        rx_ready = 1'b0;
        frame_start();
        send_bits(16'h1234, 16);
        wait_neg(2);
        check("t2_valid1", 32'(rx_valid), 32'h1);
        check("t2_data1", 32'(rx_data), 32'h1234);
        check("t2_no_overrun", 32'(overrun), 32'h0);
        send_bits(16'hBEEF, 16);
        wait_neg(2);
        check("t2_data_held", 32'(rx_data), 32'h1234);
        check("t2_valid_held", 32'(rx_valid), 32'h1);
        check("t2_overrun", 32'(overrun), 32'h1);
        rx_ready = 1'b1;
        wait_neg(1);
        rx_ready = 1'b0;
        check("t2_valid_drop", 32'(rx_valid), 32'h0);
        pulse_clear();
        check("t2_overrun_clr", 32'(overrun), 32'h0);

        // handshake on first word coincides with load of second word
        send_bits(16'h5A5A, 16);
        wait_neg(1);
        check("t3_valid1", 32'(rx_valid), 32'h1);
        check("t3_data1", 32'(rx_data), 32'h5A5A);
        send_bits(16'hC33C, 15);
        bit_setup(1'b0);
        wait_neg(3);
        rx_ready = 1'b1;
        wait_neg(1);
        rx_ready = 1'b0;
        check("t3_valid_kept", 32'(rx_valid), 32'h1);
        check("t3_data2", 32'(rx_data), 32'hC33C);
        check("t3_overrun", 32'(overrun), 32'h0);
        wait_neg(1);
        check("t3_valid_hold", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        wait_neg(3);
        frame_end();

        // early deselect after 7 bits
        frame_start();
        send_bits(16'hFE00, 7);
        check("t4_busy_mid", 32'(busy), 32'h1);
        frame_end();
        check("t4_frame_error", 32'(frame_error), 32'h1);
        check("t4_no_valid", 32'(rx_valid), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        pulse_clear();
        check("t4_fe_clr", 32'(frame_error), 32'h0);
        frame_start();
        send_bits(16'h00FF, 16);
        check("t4_data", 32'(rx_data), 32'h00FF);
        check("t4_fe_after", 32'(frame_error), 32'h0);
        frame_end();

        // sclk stalls after 5 bits: abort exactly TIMEOUT cycles after the last rise
        frame_start();
        send_bits(16'hA800, 5);
        check("t5_busy", 32'(busy), 32'h1);
        wait_neg(1021);
        check("t5_fe_not_yet", 32'(frame_error), 32'h0);
        wait_neg(1);
        check("t5_frame_error", 32'(frame_error), 32'h1);
        check("t5_busy_clr", 32'(busy), 32'h0);
        send_bits(16'h3C96, 16);
        check("t5_data", 32'(rx_data), 32'h3C96);
        check("t5_busy_after", 32'(busy), 32'h0);
        pulse_clear();
        frame_end();

        // reset mid-word: no stale bits survive
        frame_start();
        send_bits(16'h1555, 9);
        reset    = 1'b1;
        rpi_cs_n = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_rx_data", 32'(rx_data), 32'h0);
        check("t6_frame_error", 32'(frame_error), 32'h0);
        wait_neg(2);
        frame_start();
        send_bits(16'hFFFF, 15);
        bit_setup(1'b1);
        wait_neg(4);
        check("t6_valid", 32'(rx_valid), 32'h1);
        check("t6_data", 32'(rx_data), 32'hFFFF);
        check("t6_overrun", 32'(overrun), 32'h0);
        check("t6_fe", 32'(frame_error), 32'h0);
        wait_neg(5);
        frame_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
